// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps a DDS tuning word from f_start to f_stop, dwelling on each point,
// in single-shot or continuous mode.
module dds_sweep_ctrl #(
  parameter int FW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          continuous_i,
  input  logic [FW-1:0] f_start_i,
  input  logic [FW-1:0] f_stop_i,
  input  logic [FW-1:0] f_step_i,
  input  logic [DW-1:0] dwell_i,
  output logic          en_o,
  output logic          load_o,
  output logic [FW-1:0] freq_word_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [FW-1:0] cfg_start, cfg_stop, cfg_step, word_n;
  logic [DW-1:0] cfg_dwell, cnt, cnt_n;
  logic cfg_cont, en_n, load_n, busy_n, done_n, err_n, lat;
  logic [FW:0] nxt;
  logic adv;
  assign nxt = {1'b0, freq_word_o} + {1'b0, cfg_step};
  // a zero step never advances, so it must not be allowed to loop a single-shot sweep
  assign adv = (cfg_step != '0) && (nxt <= {1'b0, cfg_stop});
  always_comb begin
    state_n = state;
    en_n = 1'b0;
    load_n = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    err_n = 1'b0;
    lat = 1'b0;
    word_n = freq_word_o;
    cnt_n = cnt;
    case (state)
      IDLE: if (start_i && !abort_i) begin
        if (f_start_i <= f_stop_i) begin
          lat = 1'b1;
          state_n = LOAD;
          {en_n, load_n, busy_n} = 3'b111;
          word_n = f_start_i;
        end else err_n = 1'b1;
      end
      LOAD: begin
        state_n = RUN;
        {en_n, busy_n} = 2'b11;
        cnt_n = (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
      end
      RUN: begin
        {en_n, busy_n} = 2'b11;
        if (cnt != DW'(1)) cnt_n = cnt - DW'(1);
        else if (adv || cfg_cont) begin
          state_n = LOAD;
          load_n = 1'b1;
          word_n = adv ? nxt[FW-1:0] : cfg_start;
        end else begin
          state_n = DONE;
          {en_n, busy_n, done_n} = 3'b001;
        end
      end
      DONE: state_n = IDLE;
    endcase
    if (abort_i && state != IDLE) begin
      state_n = IDLE;
      {en_n, load_n, busy_n, done_n} = 4'b0000;
      word_n = freq_word_o;
      cnt_n = cnt;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      {en_o, load_o, busy_o, done_o, err_o} <= '0;
      freq_word_o <= '0;
      cnt <= '0;
      {cfg_start, cfg_stop, cfg_step} <= '0;
      cfg_dwell <= '0;
      cfg_cont <= 1'b0;
    end else begin
      state <= state_n;
      {en_o, load_o, busy_o, done_o, err_o} <= {en_n, load_n, busy_n, done_n, err_n};
      freq_word_o <= word_n;
      cnt <= cnt_n;
      if (lat) begin
        {cfg_start, cfg_stop, cfg_step} <= {f_start_i, f_stop_i, f_step_i};
        cfg_dwell <= dwell_i;
        cfg_cont <= continuous_i;
      end
    end
  end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Initiator side of the DDS control interface; drives the enable/load/frequency-word inputs that the DDS sin/cos control FSM consumes.
- Each step: loads a tuning word, lets the DDS run for a programmable dwell, then advances the word by a fixed increment.
- Sweep runs start to stop, in single-shot or continuous mode.
- Sits between the host/config registers and the DDS core.

Parameters:
- FW, 16, frequency tuning word width.
- DW, 16, dwell counter width.

Ports:
- clk  input  1  system clock; one clock; reset is asynchronous and active-low.
- rst  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle sweep request; sampled only in IDLE.
- abort_i  input  1  stop the sweep immediately.
- continuous_i  input  1  latched at start: 1 = restart from f_start after the last point.
- f_start_i  input  FW  first tuning word.
- f_stop_i  input  FW  last allowed tuning word.
- f_step_i  input  FW  increment per point.
- dwell_i  input  DW  RUN cycles per point; 0 is treated as 1.
- en_o  output  1  DDS enable (0 = DDS idles/clears).
- load_o  output  1  DDS load-frequency request; only meaningful while en_o = 1.
- freq_word_o  output  FW  tuning word presented to the DDS.
- busy_o  output  1  sweep in progress.
- done_o  output  1  one-cycle pulse at the end of a single-shot sweep.
- err_o  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- All outputs are registered.
- Reset values: en_o=0, load_o=0, freq_word_o=0, busy_o=0, done_o=0, err_o=0. State = IDLE.
- States: IDLE, LOAD, RUN, DONE.
- On start: f_start, f_stop, f_step, dwell and continuous are latched into config registers. Input changes during a sweep have no effect.
- IDLE:
  - en_o=0, load_o=0, busy_o=0.
  - start_i=1 with f_start_i <= f_stop_i: go to LOAD.
  - start_i=1 with f_start_i > f_stop_i: err_o=1 for one cycle; stay IDLE.
- LOAD (exactly 1 cycle):
  - en_o=1, load_o=1, busy_o=1, freq_word_o = current word.
  - Dwell counter is loaded with max(dwell,1). Go to RUN.
- RUN:
  - en_o=1, load_o=0; freq_word_o holds.
  - Counter decrements each cycle.
  - When the counter is at 1, compute nxt = cur + step in FW+1 bits (the carry is kept).
    - nxt <= f_stop: cur <= nxt; go to LOAD.
    - nxt > f_stop (includes carry-out) and continuous: cur <= f_start; go to LOAD.
    - nxt > f_stop and single-shot: go to DONE.
- DONE (exactly 1 cycle): en_o=0, load_o=0, busy_o=0, done_o=1; then IDLE.
- First LOAD cycle is the cycle after start_i is sampled.
- Each point is 1 LOAD cycle + max(dwell,1) RUN cycles.
- f_step=0: only f_start is ever loaded.
  - Single-shot: one point, then DONE.
  - Continuous: reloads f_start each period until abort.
- abort_i has priority over everything in LOAD/RUN/DONE.
  - Next cycle: IDLE with en_o=0, load_o=0, busy_o=0.
  - No done_o pulse. freq_word_o holds its last value.
- start_i outside IDLE is ignored. A simultaneous start_i and abort_i in IDLE: abort wins; stay IDLE.
- load_o is never 1 while en_o is 0.
- Async reset mid-sweep: all outputs return to reset values immediately; the sweep is lost.

Test Plan:
- Single-shot sweep: start=100, stop=130, step=10, dwell=3 -> LOAD pulses carry 100, 110, 120, 130, each followed by 3 RUN cycles; done_o in the 17th cycle after start; en_o=0 afterwards.
- Continuous wrap: start=5, stop=12, step=4, dwell=1, continuous=1 -> word sequence 5, 9, 5, 9, ...; no done_o; abort_i drops en_o and busy_o next cycle with no done_o.
- Overflow and zero dwell: FW=16, start=0xFFF0, stop=0xFFFF, step=0x20, dwell=0 -> a single point 0xFFF0 with 1 RUN cycle; carry ends the sweep; done_o pulses.
- Rejection: start=50, stop=40 -> err_o for 1 cycle; busy_o and en_o stay 0. Also start_i pulsed mid-sweep -> ignored, sequence unchanged.
- Zero step: step=0, dwell=2, single-shot -> one LOAD of f_start, 2 RUN cycles, then DONE.
- Reset: rst asserted during RUN -> all outputs 0 asynchronously; after release, a new start_i sweeps from the new f_start.
